// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared types and encodings for the pipeline stall/flush sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [4:0] X0 = 5'd0;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module   : load_use_detect
// Brief    : Flags an ID-stage read of a register still being loaded in EX.
// Revision : 1.0 - initial release
// ============================================================================
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs1_ID_i,
    input  logic [4:0] rs2_ID_i,
    input  logic [4:0] rd_EX_i,
    input  logic       RegWEn_EX_i,
    input  logic [1:0] WBSel_EX_i,
    output logic       load_use_o
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use_o = RegWEn_EX_i && (WBSel_EX_i == WB_MEM) && (rd_EX_i != X0) &&
                        ((rd_EX_i == rs1_ID_i) || (rd_EX_i == rs2_ID_i));

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Brief    : Stall/flush sequencer for the five-stage pipeline: load-use,
//            taken branches and variable-latency memory with a watchdog.
//            Optional macro PIPE_CTRL_PERF_EN adds stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       rs1_ID_i,
    input  logic [4:0]       rs2_ID_i,
    input  logic [4:0]       rd_EX_i,
    input  logic             RegWEn_EX_i,
    input  logic [1:0]       WBSel_EX_i,
    input  logic             PCSel_EX_i,
    input  logic             memacc_MEM_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             stall_IF_o,
    output logic             stall_ID_o,
    output logic             stall_EX_o,
    output logic             stall_MEM_o,
    output logic             flush_ID_o,
    output logic             flush_EX_o,
    output logic             flush_MEM_o,
    output logic             flush_WB_o,
`ifdef PIPE_CTRL_PERF_EN
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
`endif
    output logic             mem_err_o
);

    localparam int              c_wcnt_w    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_wcnt_w-1:0] c_wcnt_last = c_wcnt_w'(MEM_TIMEOUT - 1);
    localparam logic [c_wcnt_w-1:0] c_wcnt_sat  = '1;

    state_e              r_state;
    logic [c_wcnt_w-1:0] r_wcnt;
    logic                r_mem_err;
    logic                w_load_use;
    logic                w_hold;
    logic                w_abort;
    logic [c_wcnt_w-1:0] w_wcnt_inc;

    load_use_detect u_load_use_detect (
        .rs1_ID_i    (rs1_ID_i),
        .rs2_ID_i    (rs2_ID_i),
        .rd_EX_i     (rd_EX_i),
        .RegWEn_EX_i (RegWEn_EX_i),
        .WBSel_EX_i  (WBSel_EX_i),
        .load_use_o  (w_load_use)
    );

    // The entry cycle of a slow access is already held, before the state flips.
    assign w_hold     = !mem_ready_i && ((r_state == ST_MEM_WAIT) || memacc_MEM_i);
    assign w_abort    = (r_state == ST_MEM_WAIT) && !mem_ready_i && (r_wcnt == c_wcnt_last);
    assign w_wcnt_inc = (r_wcnt == c_wcnt_sat) ? r_wcnt : r_wcnt + 1'b1;

    // The release cycle advances the pipe, so branch/load-use apply there as in RUN.
    always_comb begin
        mem_req_o   = 1'b0;
        stall_IF_o  = 1'b0;
        stall_ID_o  = 1'b0;
        stall_EX_o  = 1'b0;
        stall_MEM_o = 1'b0;
        flush_ID_o  = 1'b0;
        flush_EX_o  = 1'b0;
        flush_MEM_o = 1'b0;
        flush_WB_o  = 1'b0;
        if (!rst_ni) begin
            flush_ID_o  = 1'b1;
            flush_EX_o  = 1'b1;
            flush_MEM_o = 1'b1;
            flush_WB_o  = 1'b1;
        end else begin
            mem_req_o = (r_state == ST_MEM_WAIT) || memacc_MEM_i;
            if (w_hold) begin
                stall_IF_o  = 1'b1;
                stall_ID_o  = 1'b1;
                stall_EX_o  = 1'b1;
                stall_MEM_o = 1'b1;
                flush_WB_o  = 1'b1;
            end else if (PCSel_EX_i) begin
                flush_ID_o = 1'b1;
                flush_EX_o = 1'b1;
            end else if (w_load_use) begin
                stall_IF_o = 1'b1;
                stall_ID_o = 1'b1;
                flush_EX_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_RUN;
            r_wcnt    <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_mem_err <= w_abort;
            case (r_state)
                ST_RUN: begin
                    if (w_hold) begin
                        r_state <= ST_MEM_WAIT;
                        r_wcnt  <= w_wcnt_inc;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ready_i || w_abort) begin
                        r_state <= ST_RUN;
                        r_wcnt  <= '0;
                    end else begin
                        r_wcnt <= w_wcnt_inc;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_wcnt  <= '0;
                end
            endcase
        end
    end

    assign mem_err_o = r_mem_err;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_IF_o) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (flush_ID_o || flush_EX_o) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Brief    : Directed and randomized self-checking bench for pipe_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int P_TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
    logic       reg_wen = 1'b0;
    logic [1:0] wb_sel = WB_ALU;
    logic       pc_sel = 1'b0, mem_acc = 1'b0, mem_rdy = 1'b0;

    logic mem_req, s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem, f_wb, mem_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MEM_TIMEOUT(P_TIMEOUT), .CNT_W(32)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rs1_ID_i     (rs1),
        .rs2_ID_i     (rs2),
        .rd_EX_i      (rd),
        .RegWEn_EX_i  (reg_wen),
        .WBSel_EX_i   (wb_sel),
        .PCSel_EX_i   (pc_sel),
        .memacc_MEM_i (mem_acc),
        .mem_ready_i  (mem_rdy),
        .mem_req_o    (mem_req),
        .stall_IF_o   (s_if),
        .stall_ID_o   (s_id),
        .stall_EX_o   (s_ex),
        .stall_MEM_o  (s_mem),
        .flush_ID_o   (f_id),
        .flush_EX_o   (f_ex),
        .flush_MEM_o  (f_mem),
        .flush_WB_o   (f_wb),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cnt_o  (stall_cnt),
        .flush_cnt_o  (flush_cnt),
`endif
        .mem_err_o    (mem_err)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks how many consecutive cycles the pipe has
    // been held by memory; checks every output on every falling edge.
    // ------------------------------------------------------------------
    int          m_held = 0;
    bit          m_waiting = 1'b0;
    bit          m_err = 1'b0;
    logic [31:0] m_scnt = 32'd0, m_fcnt = 32'd0;
    logic        e_req, e_sif, e_sid, e_sex, e_smem, e_fid, e_fex, e_fmem, e_fwb;
    logic        lu, hold;

    always @(negedge clk) begin
        if (!rst_n) begin
            {e_req, e_sif, e_sid, e_sex, e_smem} = 5'b00000;
            {e_fid, e_fex, e_fmem, e_fwb} = 4'b1111;
            m_held = 0; m_waiting = 1'b0; m_err = 1'b0;
            m_scnt = 32'd0; m_fcnt = 32'd0;
        end else begin
            lu   = reg_wen && (wb_sel == 2'b00) && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
            hold = !mem_rdy && (m_waiting || mem_acc);
            e_req = m_waiting || mem_acc;
            {e_sif, e_sid, e_sex, e_smem, e_fid, e_fex, e_fmem, e_fwb} = 8'b0;
            if (hold) begin
                {e_sif, e_sid, e_sex, e_smem, e_fwb} = 5'b11111;
            end else if (pc_sel) begin
                {e_fid, e_fex} = 2'b11;
            end else if (lu) begin
                {e_sif, e_sid, e_fex} = 3'b111;
            end
        end
        chk("m_req", mem_req, e_req);
        chk("m_stall_IF", s_if, e_sif);
        chk("m_stall_ID", s_id, e_sid);
        chk("m_stall_EX", s_ex, e_sex);
        chk("m_stall_MEM", s_mem, e_smem);
        chk("m_flush_ID", f_id, e_fid);
        chk("m_flush_EX", f_ex, e_fex);
        chk("m_flush_MEM", f_mem, e_fmem);
        chk("m_flush_WB", f_wb, e_fwb);
        chk("m_mem_err", mem_err, rst_n ? m_err : 1'b0);
`ifdef PIPE_CTRL_PERF_EN
        chkw("m_stall_cnt", stall_cnt, m_scnt);
        chkw("m_flush_cnt", flush_cnt, m_fcnt);
`endif
        if (rst_n) begin
            // The hold numbered P_TIMEOUT is the last one; an error follows it.
            if (hold && (m_held + 1 < P_TIMEOUT)) begin
                m_waiting = 1'b1;
                m_held    = m_held + 1;
                m_err     = 1'b0;
            end else begin
                m_err     = hold;
                m_waiting = 1'b0;
                m_held    = 0;
            end
            if (e_sif) m_scnt = m_scnt + 32'd1;
            if (e_fid || e_fex) m_fcnt = m_fcnt + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus with hand-computed expectations
    // ------------------------------------------------------------------
    task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                         input logic we, input logic [1:0] ws, input logic br,
                         input logic ma, input logic rdy);
        @(posedge clk);
        #1;
        rs1 = a1; rs2 = a2; rd = d; reg_wen = we; wb_sel = ws;
        pc_sel = br; mem_acc = ma; mem_rdy = rdy;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 5'd0, 1'b0, WB_ALU, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #3;
        chk("rst_flush_ID", f_id, 1'b1);
        chk("rst_flush_WB", f_wb, 1'b1);
        chk("rst_stall_IF", s_if, 1'b0);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_err", mem_err, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle();

        drive(5'd5, 5'd7, 5'd5, 1'b1, WB_MEM, 1'b0, 1'b0, 1'b0); #2;
        chk("lu_stall_IF", s_if, 1'b1);
        chk("lu_stall_ID", s_id, 1'b1);
        chk("lu_flush_EX", f_ex, 1'b1);
        chk("lu_flush_ID", f_id, 1'b0);
        chk("lu_stall_EX", s_ex, 1'b0);
        idle(); #2;
        chk("lu_free_stall_IF", s_if, 1'b0);

        drive(5'd0, 5'd0, 5'd0, 1'b1, WB_MEM, 1'b0, 1'b0, 1'b0); #2;
        chk("x0_stall_IF", s_if, 1'b0);
        chk("x0_flush_EX", f_ex, 1'b0);

        drive(5'd5, 5'd5, 5'd5, 1'b1, WB_ALU, 1'b0, 1'b0, 1'b0); #2;
        chk("alu_stall_IF", s_if, 1'b0);

        drive(5'd5, 5'd0, 5'd5, 1'b1, WB_MEM, 1'b1, 1'b0, 1'b0); #2;
        chk("br_flush_ID", f_id, 1'b1);
        chk("br_flush_EX", f_ex, 1'b1);
        chk("br_stall_IF", s_if, 1'b0);
        chk("br_stall_ID", s_id, 1'b0);

        for (int i = 0; i < 3; i++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, WB_ALU, 1'b0, 1'b1, 1'b0); #2;
            chk("mw_stall_IF", s_if, 1'b1);
            chk("mw_stall_MEM", s_mem, 1'b1);
            chk("mw_flush_WB", f_wb, 1'b1);
            chk("mw_flush_EX", f_ex, 1'b0);
            chk("mw_req", mem_req, 1'b1);
        end
        drive(5'd0, 5'd0, 5'd0, 1'b0, WB_ALU, 1'b0, 1'b1, 1'b1); #2;
        chk("mw_done_stall_MEM", s_mem, 1'b0);
        chk("mw_done_flush_WB", f_wb, 1'b0);
        chk("mw_done_req", mem_req, 1'b1);
        idle(); #2;
        chk("mw_run_req", mem_req, 1'b0);
        chk("mw_run_err", mem_err, 1'b0);

        for (int i = 0; i < P_TIMEOUT; i++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, WB_ALU, 1'b0, 1'b1, 1'b0); #2;
            chk("to_stall_EX", s_ex, 1'b1);
            chk("to_err_low", mem_err, 1'b0);
        end
        idle(); #2;
        chk("to_err", mem_err, 1'b1);
        chk("to_req", mem_req, 1'b0);
        chk("to_stall_IF", s_if, 1'b0);
        idle(); #2;
        chk("to_err_clr", mem_err, 1'b0);

        // Reset lands in what would have been the abort cycle.
        for (int i = 0; i < P_TIMEOUT; i++)
            drive(5'd0, 5'd0, 5'd0, 1'b0, WB_ALU, 1'b0, 1'b1, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_req", mem_req, 1'b0);
        chk("mr_flush_ID", f_id, 1'b1);
        chk("mr_flush_WB", f_wb, 1'b1);
        chk("mr_stall_MEM", s_mem, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
        chkw("mr_stall_cnt", stall_cnt, 32'd0);
        chkw("mr_flush_cnt", flush_cnt, 32'd0);
`endif
        idle();
        rst_n = 1'b1;
        #2;
        chk("mr_err", mem_err, 1'b0);
        chk("mr_req_after", mem_req, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            rst_n   = ($urandom_range(0, 299) != 0);
            rs1     = 5'($urandom_range(0, 3));
            rs2     = 5'($urandom_range(0, 3));
            rd      = 5'($urandom_range(0, 3));
            reg_wen = ($urandom_range(0, 1) == 1);
            wb_sel  = 2'($urandom_range(0, 3));
            pc_sel  = ($urandom_range(0, 3) == 0);
            mem_acc = ($urandom_range(0, 4) < 2);
            mem_rdy = ($urandom_range(0, 9) < 3);
        end
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
